// File: rtl/instrumented_adder_pkg.sv
// Shared definitions for the instrumented-adder measurement controller.
//   state_e      : measurement FSM states
//   DRAIN_CYCLES : clocks allowed for late chain edges to clear the synchroniser
//   DEF_*        : default widths used by the controller parameters
package instrumented_adder_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_COUNT_W  = 24;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, clears all flops
//   d_i     : asynchronous input level
//   pulse_o : one-clock pulse on each synchronised 0->1 transition
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/instrumented_adder_measure.sv
// Measurement controller for the instrumented adder.
// Latches LA operands into the adder, captures the settled sum, then opens
// the ring/chain path for gate_cycles clocks and counts chain_out edges.
//   wb_clk_i / wb_rst_n : clock, asynchronous active-low reset
//   start               : LA level, rising edge launches a measurement
//   gate_cycles         : ring-enable window in clocks (sampled at SETTLE exit)
//   a_in, b_in          : operands from LA       -> a_out, b_out to the adder
//   sum_in              : adder sum              -> sum_out (captured)
//   chain_in            : async chain_out        -> count (captured edge count)
//   chain_en            : ring/chain enable to the adder
//   busy, done          : measurement in progress / results valid
module instrumented_adder_measure
  import instrumented_adder_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned COUNT_W       = DEF_COUNT_W,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_cycles,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic               chain_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               chain_en,
  output logic [WIDTH-1:0]   sum_out,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + DRAIN_CYCLES);
  localparam int unsigned TW = (GATE_W > SW) ? GATE_W : SW;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
  logic               start_pulse;
  logic               chain_pulse;

  sync_edge_detect u_start_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n),
    .d_i    (start),
    .pulse_o(start_pulse)
  );

  sync_edge_detect u_chain_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n),
    .d_i    (chain_in),
    .pulse_o(chain_pulse)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    count_d = count_q;

    // Edges keep counting through DRAIN; the saturating increment is applied
    // before the capture below so an edge on the final DRAIN clock is kept.
    if (chain_pulse && (state_q == ST_COUNT || state_q == ST_DRAIN) && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_pulse) begin
          a_d     = a_in;
          b_d     = b_in;
          cnt_d   = '0;
          timer_d = TW'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          sum_d = sum_in;
          if (gate_cycles == '0) begin
            timer_d = TW'(DRAIN_CYCLES - 1);
            state_d = ST_DRAIN;
          end else begin
            timer_d = TW'(gate_cycles) - TW'(1);
            state_d = ST_COUNT;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_COUNT: begin
        if (timer_q == '0) begin
          timer_d = TW'(DRAIN_CYCLES - 1);
          state_d = ST_DRAIN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DRAIN: begin
        if (timer_q == '0) begin
          count_d = cnt_d;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign sum_out  = sum_q;
  assign count    = count_q;
  assign chain_en = (state_q == ST_COUNT);
  assign busy     = (state_q == ST_SETTLE) || (state_q == ST_COUNT) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

endmodule
